// File: rtl/edf_ic_pkg.sv
// Shared types and constants for the EDF interrupt controller family.
package edf_ic_pkg;

  // Width of the free-running machine timer and of every latency stamp.
  localparam int unsigned TsWidth = 64;

  // Handshake states of the controller-to-core bridge.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    CLAIM  = 2'd2,
    SETTLE = 2'd3
  } state_e;

endpackage : edf_ic_pkg

// File: rtl/edf_irq_bridge.sv
// Bridge between an EDF interrupt arbiter and a core interrupt pin.
// Presents the current winner to the core, follows preemption while the
// request is pending, claims on core acknowledge, and stamps claim latency.
module edf_irq_bridge
  import edf_ic_pkg::*;
#(
  parameter int unsigned  NrIrqs       = 4,
  parameter int unsigned  SettleCycles = 2,
  localparam int unsigned IdWidth      = (NrIrqs > 1) ? $clog2(NrIrqs) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 irq_valid_i,
  input  logic [IdWidth-1:0]   irq_id_i,
  output logic                 irq_ready_o,
  input  logic [TsWidth-1:0]   mtime_i,
  output logic                 core_irq_o,
  output logic [IdWidth-1:0]   core_id_o,
  input  logic                 core_ack_i,
  output logic [IdWidth-1:0]   claimed_id_o,
  output logic [TsWidth-1:0]   latency_o,
  output logic [31:0]          claim_cnt_o,
  output logic                 spurious_ack_o
);

  // The settle counter must hold SettleCycles-1; keep it at least one bit
  // wide so a zero-settle build still elaborates cleanly.
  localparam int unsigned SettleW    = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam int unsigned SettleLoad = (SettleCycles > 0) ? SettleCycles - 1 : 0;

  state_e               state_q,      state_d;
  logic [IdWidth-1:0]   core_id_q,    core_id_d;
  logic [TsWidth-1:0]   req_ts_q,     req_ts_d;
  logic [IdWidth-1:0]   claimed_id_q, claimed_id_d;
  logic [TsWidth-1:0]   latency_q,    latency_d;
  logic [31:0]          claim_cnt_q,  claim_cnt_d;
  logic [SettleW-1:0]   settle_q,     settle_d;
  logic                 spurious_q,   spurious_d;

  // Next-state and datapath decisions for the request/claim handshake.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d      = state_q;
    core_id_d    = core_id_q;
    req_ts_d     = req_ts_q;
    claimed_id_d = claimed_id_q;
    latency_d    = latency_q;
    claim_cnt_d  = claim_cnt_q;
    settle_d     = settle_q;
    spurious_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        spurious_d = core_ack_i;
        if (irq_valid_i) begin
          core_id_d = irq_id_i;
          req_ts_d  = mtime_i;
          state_d   = REQ;
        end
      end
      REQ: begin
        // Retract beats acknowledge; acknowledge beats preemption.
        if (!irq_valid_i) begin
          state_d = IDLE;
        end else if (core_ack_i) begin
          claimed_id_d = core_id_q;
          latency_d    = mtime_i - req_ts_q;
          state_d      = CLAIM;
        end else if (irq_id_i != core_id_q) begin
          core_id_d = irq_id_i;
        end
      end
      CLAIM: begin
        spurious_d  = core_ack_i;
        claim_cnt_d = claim_cnt_q + 32'd1;
        if (SettleCycles == 0) begin
          state_d = IDLE;
        end else begin
          settle_d = SettleW'(SettleLoad);
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        // The controller still shows the old winner here; ignore its valid.
        spurious_d = core_ack_i;
        if (settle_q == '0) begin
          state_d = IDLE;
        end else begin
          settle_d = settle_q - SettleW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All bridge state, cleared asynchronously so reset drops the core request at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      core_id_q    <= '0;
      req_ts_q     <= '0;
      claimed_id_q <= '0;
      latency_q    <= '0;
      claim_cnt_q  <= '0;
      settle_q     <= '0;
      spurious_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      core_id_q    <= core_id_d;
      req_ts_q     <= req_ts_d;
      claimed_id_q <= claimed_id_d;
      latency_q    <= latency_d;
      claim_cnt_q  <= claim_cnt_d;
      settle_q     <= settle_d;
      spurious_q   <= spurious_d;
    end
  end

  // Request and claim strobes decode straight from the state register.
  assign core_irq_o     = (state_q == REQ);
  assign irq_ready_o    = (state_q == CLAIM);
  assign core_id_o      = core_id_q;
  assign claimed_id_o   = claimed_id_q;
  assign latency_o      = latency_q;
  assign claim_cnt_o    = claim_cnt_q;
  assign spurious_ack_o = spurious_q;

endmodule : edf_irq_bridge

// File: tb/tb_edf_irq_bridge.sv
// Self-checking bench for edf_irq_bridge: scenario tasks plus a claim scoreboard.
module tb_edf_irq_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        irq_valid_i;
  logic [1:0]  irq_id_i;
  logic [63:0] mtime_i;
  logic        core_ack_i;

  logic        irq_ready_o, core_irq_o, spurious_ack_o;
  logic [1:0]  core_id_o, claimed_id_o;
  logic [63:0] latency_o;
  logic [31:0] claim_cnt_o;

  logic        irq_ready_z, core_irq_z, spurious_ack_z;
  logic [1:0]  core_id_z, claimed_id_z;
  logic [63:0] latency_z;
  logic [31:0] claim_cnt_z;

  always #5 clk_i = ~clk_i;

  edf_irq_bridge #(.NrIrqs(4), .SettleCycles(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .irq_valid_i(irq_valid_i), .irq_id_i(irq_id_i),
    .irq_ready_o(irq_ready_o), .mtime_i(mtime_i), .core_irq_o(core_irq_o),
    .core_id_o(core_id_o), .core_ack_i(core_ack_i), .claimed_id_o(claimed_id_o),
    .latency_o(latency_o), .claim_cnt_o(claim_cnt_o), .spurious_ack_o(spurious_ack_o)
  );

  edf_irq_bridge #(.NrIrqs(4), .SettleCycles(0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .irq_valid_i(irq_valid_i), .irq_id_i(irq_id_i),
    .irq_ready_o(irq_ready_z), .mtime_i(mtime_i), .core_irq_o(core_irq_z),
    .core_id_o(core_id_z), .core_ack_i(core_ack_i), .claimed_id_o(claimed_id_z),
    .latency_o(latency_z), .claim_cnt_o(claim_cnt_z), .spurious_ack_o(spurious_ack_z)
  );

  typedef struct {
    logic [1:0]  id;
    logic [63:0] lat;
  } claim_t;

  claim_t      sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ready_pulses = 0;
  int          exp_pulses = 0;
  logic [31:0] exp_cnt = '0;
  logic [63:0] raise_ts;

  // Counts claim pulses of the main instance, one per CLAIM cycle.
  always @(negedge clk_i) if (irq_ready_o === 1'b1) ready_pulses++;

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
    mtime_i = mtime_i + 64'd1;
  endtask

  // Ack while in REQ: push the claim the bench expects from its own bookkeeping.
  task automatic ack_now(input logic [1:0] exp_id);
    claim_t e;
    e.id  = exp_id;
    e.lat = mtime_i - raise_ts;
    sb_q.push_back(e);
    core_ack_i = 1'b1;
    step();
    core_ack_i = 1'b0;
  endtask

  // Pop the oldest expected claim and compare against the claim outputs.
  task automatic check_claim(input string name);
    claim_t e;
    checks++;
    if (irq_ready_o !== 1'b1 || sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_ready: ready=%b queued=%0d, required ready=1 with a queued claim",
               name, irq_ready_o, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      exp_pulses++;
      exp_cnt = exp_cnt + 32'd1;
      checks++;
      if (claimed_id_o !== e.id || latency_o !== e.lat || core_irq_o !== 1'b0) begin
        errors++;
        $display("FAIL %s_claim: id=%0d lat=%0d irq=%b, required id=%0d lat=%0d irq=0",
                 name, claimed_id_o, latency_o, core_irq_o, e.id, e.lat);
      end
    end
  endtask

  task automatic drain(input int n);
    irq_valid_i = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; irq_valid_i = 1'b0; irq_id_i = '0; core_ack_i = 1'b0; mtime_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({core_irq_o, irq_ready_o, core_id_o, claimed_id_o, latency_o, claim_cnt_o,
         spurious_ack_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: irq=%b rdy=%b id=%0d cid=%0d lat=%0d cnt=%0d sp=%b, required all 0",
               core_irq_o, irq_ready_o, core_id_o, claimed_id_o, latency_o, claim_cnt_o,
               spurious_ack_o);
    end
    rst_ni = 1'b1;
    step();
    checks++;
    if (core_irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: core_irq=%b, required 0", core_irq_o);
    end
  endtask

  task automatic test_basic();
    mtime_i = 64'd100; raise_ts = 64'd100;
    irq_valid_i = 1'b1; irq_id_i = 2'd2;
    step();
    checks++;
    if (core_irq_o !== 1'b1 || core_id_o !== 2'd2) begin
      errors++;
      $display("FAIL basic_raise: irq=%b id=%0d, required irq=1 id=2", core_irq_o, core_id_o);
    end
    while (mtime_i != 64'd104) step();
    ack_now(2'd2);
    irq_valid_i = 1'b0;
    check_claim("basic");
    checks++;
    if (latency_o !== 64'd4) begin
      errors++;
      $display("FAIL basic_latency: latency=%0d, required 4", latency_o);
    end
    step();
    checks++;
    if (irq_ready_o !== 1'b0 || claim_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL basic_after: ready=%b cnt=%0d, required ready=0 cnt=1", irq_ready_o, claim_cnt_o);
    end
    drain(3);
  endtask

  task automatic test_preempt();
    mtime_i = 64'd1000; raise_ts = 64'd1000;
    irq_valid_i = 1'b1; irq_id_i = 2'd1;
    step();
    irq_id_i = 2'd3;
    step();
    checks++;
    if (core_irq_o !== 1'b1 || core_id_o !== 2'd3) begin
      errors++;
      $display("FAIL preempt_update: irq=%b id=%0d, required irq=1 id=3", core_irq_o, core_id_o);
    end
    irq_id_i = 2'd0;
    ack_now(2'd3);
    irq_valid_i = 1'b0;
    check_claim("preempt");
    checks++;
    if (core_id_o !== 2'd3) begin
      errors++;
      $display("FAIL preempt_hold: core_id=%0d, required 3", core_id_o);
    end
    drain(3);
    checks++;
    if (claim_cnt_o !== exp_cnt) begin
      errors++;
      $display("FAIL preempt_count: cnt=%0d, required %0d", claim_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_retract();
    int pulses_before;
    pulses_before = ready_pulses;
    irq_valid_i = 1'b1; irq_id_i = 2'd1;
    step();
    irq_valid_i = 1'b0; core_ack_i = 1'b1;
    step();
    core_ack_i = 1'b0;
    checks++;
    if (core_irq_o !== 1'b0 || spurious_ack_o !== 1'b0 || irq_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL retract_drop: irq=%b sp=%b rdy=%b, required all 0",
               core_irq_o, spurious_ack_o, irq_ready_o);
    end
    drain(2);
    checks++;
    if (claim_cnt_o !== exp_cnt || ready_pulses !== pulses_before) begin
      errors++;
      $display("FAIL retract_noclaim: cnt=%0d pulses=%0d, required cnt=%0d pulses=%0d",
               claim_cnt_o, ready_pulses, exp_cnt, pulses_before);
    end
  endtask

  task automatic test_spurious();
    core_ack_i = 1'b1;
    step();
    core_ack_i = 1'b0;
    checks++;
    if (spurious_ack_o !== 1'b1 || core_irq_o !== 1'b0) begin
      errors++;
      $display("FAIL spurious_idle: sp=%b irq=%b, required sp=1 irq=0", spurious_ack_o, core_irq_o);
    end
    step();
    checks++;
    if (spurious_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL spurious_pulse: sp=%b, required 0", spurious_ack_o);
    end
    // Ack arriving while the bridge settles after a real claim.
    raise_ts = mtime_i; irq_valid_i = 1'b1; irq_id_i = 2'd0;
    step();
    ack_now(2'd0);
    irq_valid_i = 1'b0;
    check_claim("spurious");
    step();
    core_ack_i = 1'b1;
    step();
    core_ack_i = 1'b0;
    checks++;
    if (spurious_ack_o !== 1'b1 || irq_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL spurious_settle: sp=%b rdy=%b, required sp=1 rdy=0", spurious_ack_o, irq_ready_o);
    end
    drain(3);
  endtask

  task automatic test_settle();
    int n_main;
    int n_zero;
    raise_ts = mtime_i; irq_valid_i = 1'b1; irq_id_i = 2'd2;
    step();
    step();
    ack_now(2'd2);
    check_claim("settle");
    n_main = -1; n_zero = -1;
    for (int n = 1; n <= 10 && (n_main < 0 || n_zero < 0); n++) begin
      step();
      if (n_main < 0 && core_irq_o === 1'b1) n_main = n;
      if (n_zero < 0 && core_irq_z === 1'b1) n_zero = n;
    end
    checks++;
    if (n_main !== 4) begin
      errors++;
      $display("FAIL settle_two: re-raise after %0d cycles, required 4", n_main);
    end
    checks++;
    if (n_zero !== 2) begin
      errors++;
      $display("FAIL settle_zero: re-raise after %0d cycles, required 2", n_zero);
    end
    drain(4);
  endtask

  task automatic test_wrap();
    mtime_i = 64'hFFFF_FFFF_FFFF_FFFD; raise_ts = mtime_i;
    irq_valid_i = 1'b1; irq_id_i = 2'd1;
    step();
    mtime_i = 64'd2;
    ack_now(2'd1);
    irq_valid_i = 1'b0;
    check_claim("wrap");
    checks++;
    if (latency_o !== 64'd5) begin
      errors++;
      $display("FAIL wrap_latency: latency=%0d, required 5", latency_o);
    end
    drain(3);
  endtask

  task automatic test_reset_mid_claim();
    raise_ts = mtime_i; irq_valid_i = 1'b1; irq_id_i = 2'd2;
    step();
    core_ack_i = 1'b1;
    step();
    core_ack_i = 1'b0; irq_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (irq_ready_o !== 1'b0 || core_irq_o !== 1'b0 || claim_cnt_o !== 32'd0 ||
        latency_o !== 64'd0 || claimed_id_o !== 2'd0 || core_id_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_claim: rdy=%b irq=%b cnt=%0d lat=%0d cid=%0d id=%0d, required all 0",
               irq_ready_o, core_irq_o, claim_cnt_o, latency_o, claimed_id_o, core_id_o);
    end
    sb_q.delete();
    exp_cnt = '0;
    irq_valid_i = 1'b1; irq_id_i = 2'd3;
    #2 rst_ni = 1'b1;
    step();
    checks++;
    if (core_irq_o !== 1'b1 || core_id_o !== 2'd3 || claim_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_release: irq=%b id=%0d cnt=%0d, required irq=1 id=3 cnt=0",
               core_irq_o, core_id_o, claim_cnt_o);
    end
    drain(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_preempt();
    test_retract();
    test_spurious();
    test_settle();
    test_wrap();
    test_reset_mid_claim();
    checks++;
    if (ready_pulses !== exp_pulses) begin
      errors++;
      $display("FAIL pulse_total: pulses=%0d, required %0d", ready_pulses, exp_pulses);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule : tb_edf_irq_bridge
